// File: rtl/bp_update_queue.sv
// Serialises up to two resolved branches per cycle into a one-per-cycle predictor
// training stream through a circular FIFO, with saturating statistics counters.
module bp_update_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PCW   = 14,
  parameter int unsigned CNTW  = 32
) (
  input  logic            clk,
  input  logic            rstn,
  output logic            in_ready,
  input  logic            r0_valid,
  input  logic [PCW-1:0]  r0_pc,
  input  logic            r0_taken,
  input  logic            r0_pred,
  input  logic            r1_valid,
  input  logic [PCW-1:0]  r1_pc,
  input  logic            r1_taken,
  input  logic            r1_pred,
  output logic            upd_valid,
  output logic            upd_taken,
  output logic [PCW-1:0]  upd_pc,
  output logic            mispredict,
  output logic [CNTW-1:0] branch_cnt,
  output logic [CNTW-1:0] miss_cnt,
  output logic [CNTW-1:0] drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_W   = (AW+1)'(1);
  localparam logic [AW:0] TWO_W   = (AW+1)'(2);
  localparam logic [AW:0] HIGH_W  = (AW+1)'(DEPTH - 2);

  logic [PCW:0]    mem [DEPTH];
  logic [AW-1:0]   head, tail, tail1;
  logic [AW:0]     count, count_nxt, free, wr_n;
  logic            mis0, mis1, acc0, acc1, pop, w0, w1, m0, m1, d0, d1;

  function automatic logic [CNTW-1:0] sat_add(input logic [CNTW-1:0] a, input logic [1:0] inc);
    logic [CNTW:0] s;
    s = {1'b0, a} + (CNTW+1)'(inc);
    return s[CNTW] ? '1 : s[CNTW-1:0];
  endfunction

  // Free slots include the one vacated by this edge's pop; lane 1 is dropped before lane 0.
  always_comb begin
    mis0      = r0_taken != r0_pred;
    mis1      = r1_taken != r1_pred;
    acc0      = r0_valid;
    acc1      = r1_valid & ~(r0_valid & mis0);
    pop       = count != '0;
    free      = DEPTH_W - count + (AW+1)'(pop);
    w0        = acc0 & (free != '0);
    w1        = acc1 & (free >= (w0 ? TWO_W : ONE_W));
    d0        = acc0 & ~w0;
    d1        = acc1 & ~w1;
    m0        = w0 & mis0;
    m1        = w1 & mis1;
    wr_n      = (AW+1)'(w0) + (AW+1)'(w1);
    count_nxt = count + wr_n - (AW+1)'(pop);
    tail1     = w0 ? tail + AW'(1) : tail;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      in_ready   <= 1'b1;
      mispredict <= 1'b0;
      branch_cnt <= '0;
      miss_cnt   <= '0;
      drop_cnt   <= '0;
    end else begin
      if (pop) head <= head + AW'(1);
      tail       <= tail + AW'(wr_n);
      count      <= count_nxt;
      in_ready   <= count_nxt <= HIGH_W;
      mispredict <= m0 | m1;
      branch_cnt <= sat_add(branch_cnt, {w0 & w1, w0 ^ w1});
      miss_cnt   <= sat_add(miss_cnt, {m0 & m1, m0 ^ m1});
      drop_cnt   <= sat_add(drop_cnt, {d0 & d1, d0 ^ d1});
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && w0) mem[tail]  <= {r0_taken, r0_pc};
    if (rstn && w1) mem[tail1] <= {r1_taken, r1_pc};
  end

  assign upd_valid = rstn & pop;
  assign {upd_taken, upd_pc} = upd_valid ? mem[head] : '0;

endmodule

// File: doc/bp_update_queue.md
Name: bp_update_queue

Overview:
Collects resolved conditional-branch outcomes from the two execute lanes and serialises them into the single-entry-per-cycle training stream that the 2-bit-counter branch predictor consumes (valid / taken / pc).
Buffers bursts of up to two resolutions per cycle in a circular FIFO.
Squashes a younger same-cycle lane-1 resolution when lane 0 mispredicts.
Keeps resolved-branch and mispredict statistics counters for performance measurement.

Parameters:
DEPTH, 8, FIFO entries; power of two, at least 4.
PCW, 14, branch PC width; matches the predictor write-address width.
CNTW, 32, statistics counter width.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rstn  input  1  synchronous, active-low reset.
in_ready  output  1  registered; high when the FIFO has at least 2 free entries.
r0_valid  input  1  lane 0 (older) resolved a conditional branch this cycle.
r0_pc  input  PCW  lane 0 branch PC.
r0_taken  input  1  lane 0 actual outcome.
r0_pred  input  1  lane 0 predicted outcome.
r1_valid  input  1  lane 1 (younger) resolved a conditional branch this cycle.
r1_pc  input  PCW  lane 1 branch PC.
r1_taken  input  1  lane 1 actual outcome.
r1_pred  input  1  lane 1 predicted outcome.
upd_valid  output  1  training entry present; drives predictor is_b_ope.
upd_taken  output  1  outcome of the head entry; drives predictor is_branch.
upd_pc  output  PCW  PC of the head entry; drives predictor w_pc.
mispredict  output  1  registered one-cycle pulse: an accepted lane mispredicted last cycle.
branch_cnt  output  CNTW  number of accepted resolutions; saturating.
miss_cnt  output  CNTW  number of accepted mispredicted resolutions; saturating.
drop_cnt  output  CNTW  resolutions lost to overflow; saturating.

Behaviour:
Reset:
- On a clk edge with rstn=0: head=0, tail=0, count=0, in_ready=1, mispredict=0, all counters=0.
- upd_valid=0 during reset; upd_taken and upd_pc read as 0.
- Reset mid-burst discards all queued entries. No partial update is emitted after reset.

Acceptance:
- acc0 = r0_valid.
- acc1 = r1_valid & ~(r0_valid & (r0_taken != r0_pred)). The squashed lane-1 branch is on the wrong path: it is not counted and not enqueued.

Enqueue:
- Accepted entries are written in lane order: lane 0 at tail, then lane 1 at tail+1, or lane 1 at tail if lane 0 is not valid.
- tail advances by the number written, modulo DEPTH.

Dequeue:
- The predictor always accepts, so there is no stall input.
- upd_valid = (count != 0). upd_taken and upd_pc are combinational reads of the head slot.
- The head is popped on every edge where upd_valid=1.

Count and latency:
- next count = count + writes - pop.
- Simultaneous push and pop are legal, including at full or empty.
- An entry written at edge N is visible on upd_* in the cycle after N.
- Entries drain strictly FIFO, at one per cycle.

in_ready:
- Registered as (next count <= DEPTH-2).
- Upstream should present resolutions only while in_ready=1.

Overflow:
- Overflow is checked against free slots, with the pop in the same edge counted as freeing a slot.
- If an accepted entry does not fit, it is dropped: lane 1 first, then lane 0.
- Each dropped entry increments drop_cnt. Counts never exceed DEPTH, and the FIFO is never corrupted.

Statistics:
- branch_cnt += number of accepted lanes actually enqueued.
- miss_cnt += enqueued lanes with taken != pred.
- Both counters saturate at all-ones.
- mispredict is registered as OR(enqueued lane mispredicts).

Pointers:
- log2(DEPTH) bits wide, with natural wrap. A separate count of log2(DEPTH)+1 bits distinguishes full from empty.

Test Plan:
1. Reset then idle for 5 cycles -> upd_valid=0, in_ready=1, all counters 0.
2. Single lane-0 branch at cycle 3 (pc=0x012, taken=1, pred=1) -> cycle 4: upd_valid=1, upd_pc=0x012, upd_taken=1; cycle 5: upd_valid=0; branch_cnt=1, miss_cnt=0, mispredict never 1.
3. Dual resolution with correct predictions: lane0 pc=0x020 (taken=0, pred=0) and lane1 pc=0x021 (taken=1, pred=1) -> two consecutive upd cycles in order 0x020 then 0x021; branch_cnt=2.
4. Lane-0 mispredict with lane 1 valid: lane0 pc=0x030 (taken=1, pred=0), lane1 pc=0x031 -> only 0x030 emitted; miss_cnt=1, branch_cnt=1; mispredict pulses exactly one cycle.
5. Two valid correctly-predicted lanes every cycle, ignoring in_ready, with DEPTH=8 -> count saturates at 8; in_ready falls; drop_cnt increments one per cycle once full; drained sequence matches accepted order across pointer wrap.
6. Assert rstn=0 with 5 entries queued -> next cycle upd_valid=0; after release, the first new branch emerges with no stale entries.
